timer_dev: RTL and testbench

TIMER_DEV -- requirements
Module: timer_dev

---
 rtl/timer_dev.sv | 103 ++++++++++
 tb/tb_timer_dev.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// Memory-mapped down-counter timer: CTRL/PRESET/COUNT registers, a four-state
// IDLE/LOAD/CNT/INT sequencer, and a maskable one-shot level or auto-reload pulse irq.
module timer_dev #(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;

  logic wr_ctrl, wr_preset, auto_mode, pend_set;

  assign wr_ctrl   = sel & we & (addr == 2'd0);
  assign wr_preset = sel & we & (addr == 2'd1);
  // Only MODE=01 reloads; 10 and 11 behave as one-shot.
  assign auto_mode = (ctrl_q[2:1] == 2'b01);

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;
    pend_set = 1'b0;

    case (state_q)
      IDLE: begin
        if (ctrl_q[0]) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[0]) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          state_d = INT;
        end
      end
      INT: begin
        if (auto_mode) begin
          state_d = LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          pend_set  = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A bus write overrides the automatic EN clear; a one-shot event overrides the PEND clear.
    if (wr_ctrl | wr_preset) pend_d = 1'b0;
    if (pend_set)            pend_d = 1'b1;
    if (wr_ctrl)             ctrl_d = din[3:0];
    if (wr_preset)           preset_d = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ctrl_q   <= 4'b0000;
      preset_q <= PRESET_RST;
      count_q  <= 32'd0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    case (addr)
      2'd0:    dout = {28'd0, ctrl_q};
      2'd1:    dout = preset_q;
      2'd2:    dout = count_q;
      default: dout = 32'd0;
    endcase
  end

  assign irq = ctrl_q[3] & ((state_q == INT) | pend_q);

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: expected values are queued when a step is
// driven and popped when the corresponding DUT output is sampled.
module tb_timer_dev;

  localparam logic [31:0] PRST = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  int os_cnt[9] = '{0, 0, 5, 4, 3, 2, 1, 0, 0};
  int os_irq[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};

  timer_dev #(.PRESET_RST(PRST)) dut (
    .clk  (clk),
    .rst  (rst),
    .sel  (sel),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; din = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic exp_rd(input string tag, input logic [1:0] a, input logic [31:0] v);
    sb.push_back('{tag, v});
    addr = a;
    #1;
    compare(dout);
  endtask

  task automatic exp_irq(input string tag, input logic v);
    sb.push_back('{tag, {31'd0, v}});
    #1;
    compare({31'd0, irq});
  endtask

  initial begin
    // Reset state
    step(); step();
    exp_rd("rst_ctrl", 2'd0, 32'd0);
    exp_rd("rst_preset", 2'd1, PRST);
    exp_rd("rst_count", 2'd2, 32'd0);
    exp_irq("rst_irq", 1'b0);
    rst = 1'b0;
    step(); step();
    exp_rd("idle_count", 2'd2, 32'd0);

    // One-shot, PRESET=5, CTRL=1001
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int j = 0; j < 9; j++) begin
      exp_rd($sformatf("os_count_%0d", j), 2'd2, os_cnt[j]);
      exp_irq($sformatf("os_irq_%0d", j), os_irq[j][0]);
      step();
    end
    exp_rd("os_ctrl_en_cleared", 2'd0, 32'h8);
    step(); step();
    exp_irq("os_irq_level", 1'b1);

    // PRESET write clears pending
    wr(2'd1, 32'd10);
    exp_irq("pend_clear_irq", 1'b0);
    exp_rd("pend_clear_preset", 2'd1, 32'd10);

    // Auto-reload, PRESET=3, CTRL=1011: period 5
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int j = 0; j < 16; j++) begin
      int p;
      logic [31:0] ec;
      p = (j - 2) % 5;
      if (j < 2) ec = 0;
      else if (p < 3) ec = 32'(3 - p);
      else ec = 0;
      exp_rd($sformatf("ar_count_%0d", j), 2'd2, ec);
      exp_irq($sformatf("ar_irq_%0d", j), (j >= 5) && (j % 5 == 0));
      step();
    end

    // Asynchronous reset mid-count
    step(); step();
    rst = 1'b1;
    #1;
    exp_rd("arst_count", 2'd2, 32'd0);
    exp_rd("arst_ctrl", 2'd0, 32'd0);
    exp_rd("arst_preset", 2'd1, PRST);
    exp_irq("arst_irq", 1'b0);
    step(); step();
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      exp_rd("post_rst_count", 2'd2, 32'd0);
      exp_irq("post_rst_irq", 1'b0);
    end

    // Stop at COUNT=7 then restart from PRESET (IM=0)
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    step(); step(); step(); step();
    exp_rd("stop_pre_count", 2'd2, 32'd8);
    wr(2'd0, 32'h0);
    exp_rd("stop_count", 2'd2, 32'd7);
    step(); step();
    exp_rd("stop_hold_count", 2'd2, 32'd7);
    wr(2'd0, 32'h1);
    exp_rd("restart_0", 2'd2, 32'd7);
    step();
    exp_rd("restart_1", 2'd2, 32'd7);
    step();
    exp_rd("restart_reload", 2'd2, 32'd10);
    for (int j = 3; j < 15; j++) begin
      step();
      exp_irq($sformatf("masked_irq_%0d", j), 1'b0);
    end
    exp_rd("masked_done_count", 2'd2, 32'd0);
    exp_rd("masked_done_ctrl", 2'd0, 32'd0);
    wr(2'd0, 32'h8);
    exp_irq("im_set_after_clear", 1'b0);

    // COUNT and reserved writes ignored
    wr(2'd2, 32'h55);
    exp_rd("count_wr_ignored", 2'd2, 32'd0);
    wr(2'd3, 32'h1234_5678);
    exp_rd("addr3_reads_zero", 2'd3, 32'd0);
    exp_rd("addr3_ctrl_unchanged", 2'd0, 32'h8);

    // PRESET=0: INT at k+3
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    step(); step();
    exp_irq("p0_irq_k2", 1'b0);
    step();
    exp_irq("p0_irq_k3", 1'b1);

    // PRESET write during CNT applies at next LOAD
    wr(2'd1, 32'd4);
    wr(2'd0, 32'hB);
    step(); step(); step();
    exp_rd("pw_count_k3", 2'd2, 32'd3);
    wr(2'd1, 32'd9);
    exp_rd("pw_count_k4", 2'd2, 32'd2);
    step();
    exp_rd("pw_count_k5", 2'd2, 32'd1);
    step();
    exp_irq("pw_irq_k6", 1'b1);
    step();
    exp_rd("pw_count_k7", 2'd2, 32'd0);
    step();
    exp_rd("pw_reload_k8", 2'd2, 32'd9);

    // CTRL write coinciding with one-shot INT
    rst = 1'b1;
    step();
    rst = 1'b0;
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    step(); step(); step();
    exp_irq("coll_irq_k3", 1'b0);
    step();
    exp_irq("coll_irq_int", 1'b1);
    wr(2'd0, 32'h9);
    exp_irq("coll_irq_pend", 1'b1);
    exp_rd("coll_ctrl_bus_wins", 2'd0, 32'h9);

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
